// File: rtl/uoe_csr_mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uoe_csr_mc_pkg
//  Purpose  : Shared constants, register offsets and channel config struct
//             for the multi-channel UDP offload engine CSR block.
//  Revision : 1.0  initial release
// ============================================================================
package uoe_csr_mc_pkg;

    // DFH: {feature_type, reserved, eol, next_offset, revision, feature_id}
    localparam logic [63:0] DFH_HEADER          = {4'h1, 19'h0, 1'b1, 24'h0, 4'h0, 12'h0A1};
    localparam logic [63:0] ID_LO               = 64'h8D7B_4A24_93E6_10B1;
    localparam logic [63:0] ID_HI               = 64'h5C4D_A3F2_01E7_4C3A;
    localparam logic [63:0] NEXT_AFU_OFFSET     = 64'h0;
    localparam logic [63:0] REG_RD_BADADDR_DATA = 64'hBAAD_BEEF_DEAD_BEEF;

    localparam logic [3:0] G_DFH         = 4'd0;
    localparam logic [3:0] G_ID_LO       = 4'd1;
    localparam logic [3:0] G_ID_HI       = 4'd2;
    localparam logic [3:0] G_NEXT_AFU    = 4'd3;
    localparam logic [3:0] G_SCRATCHPAD  = 4'd4;
    localparam logic [3:0] G_NUM_CH      = 4'd5;

    localparam logic [3:0] CH_FPGA_MAC   = 4'd0;
    localparam logic [3:0] CH_FPGA_IP    = 4'd1;
    localparam logic [3:0] CH_FPGA_PORT  = 4'd2;
    localparam logic [3:0] CH_NETMASK    = 4'd3;
    localparam logic [3:0] CH_HOST_MAC   = 4'd4;
    localparam logic [3:0] CH_HOST_IP    = 4'd5;
    localparam logic [3:0] CH_HOST_PORT  = 4'd6;
    localparam logic [3:0] CH_PAYLOAD    = 4'd7;
    localparam logic [3:0] CH_CHECKSUM   = 4'd8;
    localparam logic [3:0] CH_RESET      = 4'd9;
    localparam logic [3:0] CH_STATUS     = 4'd10;
    localparam logic [3:0] CH_MISC       = 4'd11;
    localparam logic [3:0] CH_COMMIT     = 4'd12;
    localparam logic [3:0] CH_TX_PKT_CNT = 4'd13;
    localparam logic [3:0] CH_RX_PKT_CNT = 4'd14;

    typedef struct packed {
        logic [47:0] fpga_mac;
        logic [31:0] fpga_ip;
        logic [15:0] fpga_port;
        logic [31:0] netmask;
        logic [47:0] host_mac;
        logic [31:0] host_ip;
        logic [15:0] host_port;
        logic [15:0] payload;
        logic [15:0] checksum;
        logic [63:0] misc;
    } ch_cfg_t;

    function automatic logic [63:0] apply_be(input logic [63:0] old_val,
                                             input logic [63:0] wdata,
                                             input logic [7:0]  be);
        logic [63:0] merged;
        merged = old_val;
        for (int i = 0; i < 8; i++) begin
            if (be[i]) merged[i*8 +: 8] = wdata[i*8 +: 8];
        end
        return merged;
    endfunction

    // Words that live in the shadow/active pair and are subject to commit
    function automatic logic is_cfg_word(input logic [3:0] word);
        return (word <= CH_CHECKSUM) || (word == CH_MISC);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uoe_csr_ch_bank.sv
`default_nettype none
// ============================================================================
//  Module   : uoe_csr_ch_bank
//  Purpose  : One channel register bank: shadow/active config with commit,
//             self-timed reset pulses, clear-on-read packet counters.
//  Revision : 1.0  initial release
// ============================================================================
module uoe_csr_ch_bank
    import uoe_csr_mc_pkg::*;
#(
    parameter int RST_PULSE_CYCLES = 16,
    parameter int CNT_W            = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr_en,
    input  logic        i_rd_en,
    input  logic [3:0]  i_word,
    input  logic [63:0] i_wdata,
    input  logic [7:0]  i_be,
    input  logic [31:0] i_tx_status,
    input  logic [31:0] i_rx_status,
    input  logic        i_tx_pkt_done,
    input  logic        i_rx_pkt_done,
    output ch_cfg_t     o_active,
    output logic        o_csr_rst,
    output logic        o_tx_rst,
    output logic        o_rx_rst,
    output logic [63:0] o_rd_data
);

    localparam int             PW         = $clog2(RST_PULSE_CYCLES + 1);
    localparam logic [PW-1:0]  C_PULSE_LD = PW'(RST_PULSE_CYCLES);

    ch_cfg_t            r_shadow;
    ch_cfg_t            r_active;
    logic               r_pending;
    logic [PW-1:0]      r_pulse [3];
    logic [CNT_W-1:0]   r_tx_cnt;
    logic [CNT_W-1:0]   r_rx_cnt;

    logic               w_cfg_wr;
    logic               w_commit;
    logic               w_rst_wr;
    logic               w_tx_clr;
    logic               w_rx_clr;
    logic [63:0]        w_shadow_word;
    logic [63:0]        w_merged;

    assign w_cfg_wr = i_wr_en && is_cfg_word(i_word);
    assign w_commit = i_wr_en && (i_word == CH_COMMIT) && i_be[0] && i_wdata[0];
    assign w_rst_wr = i_wr_en && (i_word == CH_RESET) && i_be[0];
    assign w_tx_clr = i_rd_en && (i_word == CH_TX_PKT_CNT);
    assign w_rx_clr = i_rd_en && (i_word == CH_RX_PKT_CNT);

    always_comb begin
        w_shadow_word = '0;
        case (i_word)
            CH_FPGA_MAC:  w_shadow_word = 64'(r_shadow.fpga_mac);
            CH_FPGA_IP:   w_shadow_word = 64'(r_shadow.fpga_ip);
            CH_FPGA_PORT: w_shadow_word = 64'(r_shadow.fpga_port);
            CH_NETMASK:   w_shadow_word = 64'(r_shadow.netmask);
            CH_HOST_MAC:  w_shadow_word = 64'(r_shadow.host_mac);
            CH_HOST_IP:   w_shadow_word = 64'(r_shadow.host_ip);
            CH_HOST_PORT: w_shadow_word = 64'(r_shadow.host_port);
            CH_PAYLOAD:   w_shadow_word = 64'(r_shadow.payload);
            CH_CHECKSUM:  w_shadow_word = 64'(r_shadow.checksum);
            CH_MISC:      w_shadow_word = r_shadow.misc;
            default:      w_shadow_word = '0;
        endcase
    end

    // Merge on the full 64-bit view, then truncate to the field width
    assign w_merged = apply_be(w_shadow_word, i_wdata, i_be);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
        end else if (w_cfg_wr) begin
            r_pending <= 1'b1;
            case (i_word)
                CH_FPGA_MAC:  r_shadow.fpga_mac  <= w_merged[47:0];
                CH_FPGA_IP:   r_shadow.fpga_ip   <= w_merged[31:0];
                CH_FPGA_PORT: r_shadow.fpga_port <= w_merged[15:0];
                CH_NETMASK:   r_shadow.netmask   <= w_merged[31:0];
                CH_HOST_MAC:  r_shadow.host_mac  <= w_merged[47:0];
                CH_HOST_IP:   r_shadow.host_ip   <= w_merged[31:0];
                CH_HOST_PORT: r_shadow.host_port <= w_merged[15:0];
                CH_PAYLOAD:   r_shadow.payload   <= w_merged[15:0];
                CH_CHECKSUM:  r_shadow.checksum  <= w_merged[15:0];
                CH_MISC:      r_shadow.misc      <= w_merged;
                default:      ;
            endcase
        end else if (w_commit) begin
            r_active  <= r_shadow;
            r_pending <= 1'b0;
        end
    end

    // Index 2 = csr, 1 = tx, 0 = rx, matching the RESET word bit layout
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) r_pulse[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_rst_wr && i_wdata[i]) begin
                    r_pulse[i] <= C_PULSE_LD;
                end else if (r_pulse[i] != '0) begin
                    r_pulse[i] <= r_pulse[i] - PW'(1);
                end
            end
        end
    end

    // A read clears the counter but keeps a strobe landing on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_cnt <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_tx_clr) begin
                r_tx_cnt <= CNT_W'(i_tx_pkt_done);
            end else if (i_tx_pkt_done && (r_tx_cnt != '1)) begin
                r_tx_cnt <= r_tx_cnt + CNT_W'(1);
            end
            if (w_rx_clr) begin
                r_rx_cnt <= CNT_W'(i_rx_pkt_done);
            end else if (i_rx_pkt_done && (r_rx_cnt != '1)) begin
                r_rx_cnt <= r_rx_cnt + CNT_W'(1);
            end
        end
    end

    assign o_active  = r_active;
    assign o_csr_rst = (r_pulse[2] != '0);
    assign o_tx_rst  = (r_pulse[1] != '0);
    assign o_rx_rst  = (r_pulse[0] != '0);

    always_comb begin
        o_rd_data = REG_RD_BADADDR_DATA;
        if (is_cfg_word(i_word)) begin
            o_rd_data = w_shadow_word;
        end else begin
            case (i_word)
                CH_RESET:      o_rd_data = {61'b0, o_csr_rst, o_tx_rst, o_rx_rst};
                CH_STATUS:     o_rd_data = {i_tx_status, i_rx_status};
                CH_COMMIT:     o_rd_data = {63'b0, r_pending};
                CH_TX_PKT_CNT: o_rd_data = 64'(r_tx_cnt);
                CH_RX_PKT_CNT: o_rd_data = 64'(r_rx_cnt);
                default:       o_rd_data = REG_RD_BADADDR_DATA;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uoe_csr_mc.sv
`default_nettype none
// ============================================================================
//  Module   : uoe_csr_mc
//  Purpose  : Multi-channel UOE CSR: Avalon-MM decode, global DFH region and
//             NUM_CHANNELS per-channel banks behind one 64-bit slave.
//  Revision : 1.0  initial release
// ============================================================================
module uoe_csr_mc
    import uoe_csr_mc_pkg::*;
#(
    parameter int NUM_CHANNELS     = 2,
    parameter int ADDR_W           = 16,
    parameter int CH_STRIDE_BYTES  = 256,
    parameter int RST_PULSE_CYCLES = 16,
    parameter int CNT_W            = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            avmm_address,
    input  logic                         avmm_read,
    input  logic                         avmm_write,
    input  logic [63:0]                  avmm_writedata,
    input  logic [7:0]                   avmm_byteenable,
    output logic [63:0]                  avmm_readdata,
    output logic                         avmm_readdatavalid,
    output logic                         avmm_waitrequest,
    output logic [NUM_CHANNELS*48-1:0]   ch_fpga_mac,
    output logic [NUM_CHANNELS*32-1:0]   ch_fpga_ip,
    output logic [NUM_CHANNELS*32-1:0]   ch_fpga_netmask,
    output logic [NUM_CHANNELS*32-1:0]   ch_host_ip,
    output logic [NUM_CHANNELS*48-1:0]   ch_host_mac,
    output logic [NUM_CHANNELS*16-1:0]   ch_fpga_port,
    output logic [NUM_CHANNELS*16-1:0]   ch_host_port,
    output logic [NUM_CHANNELS*16-1:0]   ch_payload_per_packet,
    output logic [NUM_CHANNELS*16-1:0]   ch_checksum_ip,
    output logic [NUM_CHANNELS*64-1:0]   ch_misc_ctrl,
    output logic [NUM_CHANNELS-1:0]      ch_csr_rst,
    output logic [NUM_CHANNELS-1:0]      ch_tx_rst,
    output logic [NUM_CHANNELS-1:0]      ch_rx_rst,
    input  logic [NUM_CHANNELS*32-1:0]   ch_tx_status,
    input  logic [NUM_CHANNELS*32-1:0]   ch_rx_status,
    input  logic [NUM_CHANNELS-1:0]      ch_tx_pkt_done,
    input  logic [NUM_CHANNELS-1:0]      ch_rx_pkt_done
);

    localparam int SB     = $clog2(CH_STRIDE_BYTES);
    localparam int WORD_W = SB - 3;
    localparam int REG_W  = ADDR_W - SB;

    logic [REG_W-1:0]        w_region;
    logic [WORD_W-1:0]       w_word;
    logic [3:0]              w_word4;
    logic                    w_word_ok;
    logic                    w_is_global;
    logic [NUM_CHANNELS-1:0] w_ch_hit;
    logic [63:0]             w_ch_rd [NUM_CHANNELS];
    logic [63:0]             w_rd_mux;
    logic                    w_unused;

    logic [63:0]             r_readdata;
    logic                    r_readdatavalid;
    logic [63:0]             r_scratch;

    // Region 0 is the global DFH block; region c+1 is channel c
    assign w_region    = avmm_address[ADDR_W-1:SB];
    assign w_word      = avmm_address[SB-1:3];
    assign w_word4     = w_word[3:0];
    assign w_word_ok   = (32'(w_word) < 32'd16);
    assign w_is_global = (w_region == '0);
    assign w_unused    = ^avmm_address[2:0];

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        ch_cfg_t w_active;

        assign w_ch_hit[c] = (32'(w_region) == 32'(c + 1)) && w_word_ok;

        uoe_csr_ch_bank #(
            .RST_PULSE_CYCLES (RST_PULSE_CYCLES),
            .CNT_W            (CNT_W)
        ) u_bank (
            .clk           (clk),
            .rst           (rst),
            .i_wr_en       (avmm_write && w_ch_hit[c]),
            .i_rd_en       (avmm_read && w_ch_hit[c]),
            .i_word        (w_word4),
            .i_wdata       (avmm_writedata),
            .i_be          (avmm_byteenable),
            .i_tx_status   (ch_tx_status[c*32 +: 32]),
            .i_rx_status   (ch_rx_status[c*32 +: 32]),
            .i_tx_pkt_done (ch_tx_pkt_done[c]),
            .i_rx_pkt_done (ch_rx_pkt_done[c]),
            .o_active      (w_active),
            .o_csr_rst     (ch_csr_rst[c]),
            .o_tx_rst      (ch_tx_rst[c]),
            .o_rx_rst      (ch_rx_rst[c]),
            .o_rd_data     (w_ch_rd[c])
        );

        assign ch_fpga_mac[c*48 +: 48]           = w_active.fpga_mac;
        assign ch_fpga_ip[c*32 +: 32]            = w_active.fpga_ip;
        assign ch_fpga_netmask[c*32 +: 32]       = w_active.netmask;
        assign ch_host_ip[c*32 +: 32]            = w_active.host_ip;
        assign ch_host_mac[c*48 +: 48]           = w_active.host_mac;
        assign ch_fpga_port[c*16 +: 16]          = w_active.fpga_port;
        assign ch_host_port[c*16 +: 16]          = w_active.host_port;
        assign ch_payload_per_packet[c*16 +: 16] = w_active.payload;
        assign ch_checksum_ip[c*16 +: 16]        = w_active.checksum;
        assign ch_misc_ctrl[c*64 +: 64]          = w_active.misc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scratch <= '0;
        end else if (avmm_write && w_is_global && w_word_ok && (w_word4 == G_SCRATCHPAD)) begin
            r_scratch <= apply_be(r_scratch, avmm_writedata, avmm_byteenable);
        end
    end

    always_comb begin
        w_rd_mux = REG_RD_BADADDR_DATA;
        if (w_is_global && w_word_ok) begin
            case (w_word4)
                G_DFH:        w_rd_mux = DFH_HEADER;
                G_ID_LO:      w_rd_mux = ID_LO;
                G_ID_HI:      w_rd_mux = ID_HI;
                G_NEXT_AFU:   w_rd_mux = NEXT_AFU_OFFSET;
                G_SCRATCHPAD: w_rd_mux = r_scratch;
                G_NUM_CH:     w_rd_mux = 64'(NUM_CHANNELS);
                default:      w_rd_mux = REG_RD_BADADDR_DATA;
            endcase
        end
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (w_ch_hit[c]) w_rd_mux = w_ch_rd[c];
        end
    end

    // Sampling the mux at the request edge yields the pre-write value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
        end else begin
            r_readdata      <= avmm_read ? w_rd_mux : '0;
            r_readdatavalid <= avmm_read;
        end
    end

    assign avmm_readdata      = r_readdata;
    assign avmm_readdatavalid = r_readdatavalid;
    assign avmm_waitrequest   = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_uoe_csr_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uoe_csr_mc
//  Purpose  : Self-checking bench for uoe_csr_mc (vector table, directed
//             corner sequences, randomized config traffic vs. a model).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uoe_csr_mc;

    localparam logic [63:0] C_BAD = 64'hBAAD_BEEF_DEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] address;
    logic        read, write;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [63:0] rdata;
    logic        rdv, wreq;
    logic [95:0]  o_fmac, o_hmac;
    logic [63:0]  o_fip, o_nm, o_hip;
    logic [31:0]  o_fport, o_hport, o_pl, o_cs;
    logic [127:0] o_misc;
    logic [1:0]   o_crst, o_trst, o_rrst;
    logic [63:0]  tx_status, rx_status;
    logic [1:0]   tx_done, rx_done;

    logic [15:0] a4;
    logic        rd4, done4, rdv4, wreq4;
    logic [63:0] rdata4;
    logic [47:0] m4_fmac, m4_hmac;
    logic [31:0] m4_fip, m4_nm, m4_hip;
    logic [15:0] m4_fp, m4_hp, m4_pl, m4_cs;
    logic [63:0] m4_misc;
    logic        m4_crst, m4_trst, m4_rrst;

    uoe_csr_mc #(.NUM_CHANNELS(2)) dut (
        .clk(clk), .rst(rst), .avmm_address(address), .avmm_read(read),
        .avmm_write(write), .avmm_writedata(wdata), .avmm_byteenable(be),
        .avmm_readdata(rdata), .avmm_readdatavalid(rdv), .avmm_waitrequest(wreq),
        .ch_fpga_mac(o_fmac), .ch_fpga_ip(o_fip), .ch_fpga_netmask(o_nm),
        .ch_host_ip(o_hip), .ch_host_mac(o_hmac), .ch_fpga_port(o_fport),
        .ch_host_port(o_hport), .ch_payload_per_packet(o_pl), .ch_checksum_ip(o_cs),
        .ch_misc_ctrl(o_misc), .ch_csr_rst(o_crst), .ch_tx_rst(o_trst), .ch_rx_rst(o_rrst),
        .ch_tx_status(tx_status), .ch_rx_status(rx_status),
        .ch_tx_pkt_done(tx_done), .ch_rx_pkt_done(rx_done)
    );

    uoe_csr_mc #(.NUM_CHANNELS(1), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .avmm_address(a4), .avmm_read(rd4),
        .avmm_write(1'b0), .avmm_writedata(64'h0), .avmm_byteenable(8'h0),
        .avmm_readdata(rdata4), .avmm_readdatavalid(rdv4), .avmm_waitrequest(wreq4),
        .ch_fpga_mac(m4_fmac), .ch_fpga_ip(m4_fip), .ch_fpga_netmask(m4_nm),
        .ch_host_ip(m4_hip), .ch_host_mac(m4_hmac), .ch_fpga_port(m4_fp),
        .ch_host_port(m4_hp), .ch_payload_per_packet(m4_pl), .ch_checksum_ip(m4_cs),
        .ch_misc_ctrl(m4_misc), .ch_csr_rst(m4_crst), .ch_tx_rst(m4_trst), .ch_rx_rst(m4_rrst),
        .ch_tx_status(32'h0), .ch_rx_status(32'h0),
        .ch_tx_pkt_done(done4), .ch_rx_pkt_done(1'b0)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [63:0] d, input logic [7:0] b);
        address = a; wdata = d; be = b; write = 1'b1;
        @(posedge clk); #1;
        write = 1'b0; be = 8'h0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [63:0] d);
        address = a; read = 1'b1;
        @(posedge clk); #1;
        read = 1'b0;
        d = rdata;
    endtask

    // Reference model: per-word shadow/active images, field widths per word
    logic [63:0] sh [2][16];
    logic [63:0] ac [2][16];
    logic        pend [2];
    logic [63:0] scr;
    int fw [16] = '{48, 32, 16, 32, 48, 32, 16, 16, 16, 0, 0, 64, 0, 0, 0, 0};
    int cw [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 11};

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] lanes, input int w);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (lanes[i]) r[i*8 +: 8] = d[i*8 +: 8];
        if (w < 64) r = r & ((64'd1 << w) - 64'd1);
        return r;
    endfunction

    task automatic check_actives(input string tag);
        logic [95:0]  e_fmac, e_hmac;
        logic [63:0]  e_fip, e_nm, e_hip;
        logic [31:0]  e_fp, e_hp, e_pl, e_cs;
        logic [127:0] e_misc;
        for (int c = 0; c < 2; c++) begin
            e_fmac[c*48 +: 48] = ac[c][0][47:0];
            e_fip[c*32 +: 32]  = ac[c][1][31:0];
            e_fp[c*16 +: 16]   = ac[c][2][15:0];
            e_nm[c*32 +: 32]   = ac[c][3][31:0];
            e_hmac[c*48 +: 48] = ac[c][4][47:0];
            e_hip[c*32 +: 32]  = ac[c][5][31:0];
            e_hp[c*16 +: 16]   = ac[c][6][15:0];
            e_pl[c*16 +: 16]   = ac[c][7][15:0];
            e_cs[c*16 +: 16]   = ac[c][8][15:0];
            e_misc[c*64 +: 64] = ac[c][11];
        end
        chk({tag, " fpga_mac"}, o_fmac, e_fmac);
        chk({tag, " fpga_ip"}, o_fip, e_fip);
        chk({tag, " fpga_port"}, o_fport, e_fp);
        chk({tag, " netmask"}, o_nm, e_nm);
        chk({tag, " host_mac"}, o_hmac, e_hmac);
        chk({tag, " host_ip"}, o_hip, e_hip);
        chk({tag, " host_port"}, o_hport, e_hp);
        chk({tag, " payload"}, o_pl, e_pl);
        chk({tag, " checksum"}, o_cs, e_cs);
        chk({tag, " misc"}, o_misc, e_misc);
    endtask

    task automatic pulse_run(input int rewrite_at, output int hi_cnt, output int others);
        hi_cnt = 0; others = 0;
        address = 16'h0248; wdata = 64'h2; be = 8'h01; write = 1'b1;
        @(posedge clk); #1;
        write = 1'b0;
        for (int j = 0; j < 40; j++) begin
            if (o_trst[1]) hi_cnt++;
            if (o_trst[0] || o_crst[1] || o_rrst[1] || o_crst[0] || o_rrst[0]) others++;
            if (j == rewrite_at) write = 1'b1;
            @(posedge clk); #1;
            write = 1'b0;
        end
        be = 8'h0;
    endtask

    task automatic strobe_tx0();
        tx_done[0] = 1'b1; @(posedge clk); #1;
        tx_done[0] = 1'b0; @(posedge clk); #1;
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [63:0] exp;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs [17];
        logic [63:0] d;
        int          hi_cnt, others;

        vecs[0]  = '{16'h0028, 64'd2};
        vecs[1]  = '{16'h0078, C_BAD};
        vecs[2]  = '{16'h0300, C_BAD};
        vecs[3]  = '{16'h0000, 64'h1000_0100_0000_00A1};
        vecs[4]  = '{16'h0008, 64'h8D7B_4A24_93E6_10B1};
        vecs[5]  = '{16'h0010, 64'h5C4D_A3F2_01E7_4C3A};
        vecs[6]  = '{16'h0018, 64'h0};
        vecs[7]  = '{16'h0020, 64'h0};
        vecs[8]  = '{16'h0030, C_BAD};
        vecs[9]  = '{16'h0150, 64'h1111_0001_3333_0003};
        vecs[10] = '{16'h0250, 64'h2222_0002_4444_0004};
        vecs[11] = '{16'h0160, 64'h0};
        vecs[12] = '{16'h0178, C_BAD};
        vecs[13] = '{16'h0180, C_BAD};
        vecs[14] = '{16'h0248, 64'h0};
        vecs[15] = '{16'h0108, 64'h0};
        vecs[16] = '{16'hFF00, C_BAD};

        rst = 1'b1; address = '0; read = 0; write = 0; wdata = '0; be = '0;
        tx_status = {32'h2222_0002, 32'h1111_0001};
        rx_status = {32'h4444_0004, 32'h3333_0003};
        tx_done = '0; rx_done = '0; a4 = '0; rd4 = 0; done4 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset rdv", rdv, 1'b0);
        chk("reset rdata", rdata, 64'h0);
        chk("reset fpga_mac", o_fmac, 96'h0);
        chk("reset rst pulses", {o_crst, o_trst, o_rrst}, 6'h0);
        chk("waitrequest", wreq, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) begin
            rd(vecs[i].addr, d);
            chk($sformatf("tbl%0d rdv", i), rdv, 1'b1);
            chk($sformatf("tbl%0d data", i), d, vecs[i].exp);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d rdv idle", i), rdv, 1'b0);
        end

        wr(16'h0108, 64'hFFFF_FFFF, 8'hFF);
        wr(16'h0108, 64'hC0A8_0001, 8'h03);
        rd(16'h0108, d);
        chk("be ip shadow", d, 64'hFFFF_0001);
        chk("be ip active before commit", o_fip[31:0], 32'h0);
        rd(16'h0160, d);
        chk("commit pending", d, 64'h1);
        wr(16'h0160, 64'h1, 8'h01);
        chk("ip active after commit", o_fip[31:0], 32'hFFFF_0001);
        chk("ch1 ip untouched", o_fip[63:32], 32'h0);
        rd(16'h0160, d);
        chk("commit cleared", d, 64'h0);

        // Read and write of the same word on one edge returns the old value
        address = 16'h0020; wdata = 64'h1234_5678_9ABC_DEF0; be = 8'hFF;
        write = 1'b1; read = 1'b1;
        @(posedge clk); #1;
        write = 1'b0; read = 1'b0; be = 8'h0;
        chk("rd-wr same edge", rdata, 64'h0);
        rd(16'h0020, d);
        chk("scratch after write", d, 64'h1234_5678_9ABC_DEF0);

        pulse_run(-1, hi_cnt, others);
        chk("tx_rst pulse len", 32'(hi_cnt), 32'd16);
        chk("pulse isolation", 32'(others), 32'd0);
        pulse_run(9, hi_cnt, others);
        chk("tx_rst extended len", 32'(hi_cnt), 32'd26);
        chk("ext pulse isolation", 32'(others), 32'd0);

        repeat (5) strobe_tx0();
        address = 16'h0168; read = 1'b1; tx_done[0] = 1'b1;
        @(posedge clk); #1;
        read = 1'b0; tx_done[0] = 1'b0;
        chk("tx cnt 5", rdata, 64'd5);
        rd(16'h0168, d);
        chk("tx cnt after coincident", d, 64'd1);
        rd(16'h0168, d);
        chk("tx cnt cleared", d, 64'd0);
        repeat (3) begin
            rx_done[1] = 1'b1; @(posedge clk); #1; rx_done[1] = 1'b0;
        end
        rd(16'h0270, d);
        chk("ch1 rx cnt", d, 64'd3);
        rd(16'h0170, d);
        chk("ch0 rx cnt", d, 64'd0);

        repeat (20) begin
            done4 = 1'b1; @(posedge clk); #1;
        end
        done4 = 1'b0;
        a4 = 16'h0168; rd4 = 1'b1;
        @(posedge clk); #1;
        rd4 = 1'b0;
        chk("cnt4 rdv", rdv4, 1'b1);
        chk("cnt4 saturated", rdata4, 64'd15);
        a4 = 16'h0028; rd4 = 1'b1;
        @(posedge clk); #1;
        rd4 = 1'b0;
        chk("dut4 num_ch", rdata4, 64'd1);

        wr(16'h0110, 64'h1234, 8'h03);
        wr(16'h0160, 64'h1, 8'h01);
        chk("port active", o_fport[15:0], 16'h1234);
        wr(16'h0110, 64'h5678, 8'h03);
        wr(16'h0148, 64'h7, 8'h01);
        chk("pulses on", {o_crst[0], o_trst[0], o_rrst[0]}, 3'b111);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst drops pulses", {o_crst, o_trst, o_rrst}, 6'h0);
        chk("rst clears active port", o_fport, 32'h0);
        rst = 1'b0;
        rd(16'h0160, d);
        chk("rst clears pending", d, 64'h0);
        rd(16'h0110, d);
        chk("rst clears shadow", d, 64'h0);
        rd(16'h0020, d);
        chk("rst clears scratch", d, 64'h0);

        for (int c = 0; c < 2; c++) begin
            pend[c] = 1'b0;
            for (int w = 0; w < 16; w++) begin
                sh[c][w] = '0; ac[c][w] = '0;
            end
        end
        scr = '0;
        for (int it = 0; it < 300; it++) begin
            int          op, c, w;
            logic [15:0] base;
            logic [63:0] rd_val, dv;
            logic [7:0]  bv;
            op   = int'($urandom_range(0, 9));
            c    = int'($urandom_range(0, 1));
            base = 16'(256 * (c + 1));
            w    = cw[$urandom_range(0, 9)];
            dv   = {$urandom, $urandom};
            bv   = 8'($urandom);
            if (op <= 4) begin
                wr(base + 16'(8 * w), dv, bv);
                sh[c][w] = merge(sh[c][w], dv, bv, fw[w]);
                pend[c]  = 1'b1;
            end else if (op == 5) begin
                wr(base + 16'h60, dv, 8'h01);
                if (dv[0]) begin
                    for (int k = 0; k < 16; k++) ac[c][k] = sh[c][k];
                    pend[c] = 1'b0;
                end
            end else if (op <= 7) begin
                rd(base + 16'(8 * w), rd_val);
                chk($sformatf("rand shadow ch%0d w%0d", c, w), rd_val, sh[c][w]);
            end else if (op == 8) begin
                rd(base + 16'h60, rd_val);
                chk($sformatf("rand pending ch%0d", c), rd_val, {63'b0, pend[c]});
            end else if (dv[63]) begin
                wr(16'h0020, dv, bv);
                scr = merge(scr, dv, bv, 64);
            end else begin
                rd(16'h0020, rd_val);
                chk("rand scratch", rd_val, scr);
            end
            if (op == 5 || (it % 25) == 0) check_actives($sformatf("rand%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uoe_csr_mc.md
Name: uoe_csr_mc

Overview:
- Multi-channel CSR block for the UDP offload engine. Exposes one Avalon-MM 64-bit slave carrying a global DFH region plus NUM_CHANNELS identical per-channel register banks.
- Adds capabilities the single-channel CSR lacks:
  - byte-enable writes;
  - shadow/active configuration with atomic per-channel commit;
  - self-timed reset pulses;
  - saturating clear-on-read packet counters.
- Sits between the host CSR interconnect and the per-channel UDP TX/RX engines.

Parameters:
- NUM_CHANNELS, 2, number of channel banks (1..8).
- ADDR_W, 16, byte-address width.
- CH_STRIDE_BYTES, 256, byte spacing of channel banks; bank c base = (c+1)*CH_STRIDE_BYTES; must be a power of 2 and ≥128.
- RST_PULSE_CYCLES, 16, length of a CSR-initiated reset pulse (≥1).
- CNT_W, 32, packet counter width (≤64).

Ports:
- clk  in  1  CSR clock.
- rst  in  1  Synchronous active-high reset.
- avmm_address  in  ADDR_W  Byte address; register index = address>>3.
- avmm_read  in  1  Read request.
- avmm_write  in  1  Write request.
- avmm_writedata  in  64  Write data.
- avmm_byteenable  in  8  Byte lanes for writes.
- avmm_readdata  out  64  Read data.
- avmm_readdatavalid  out  1  Read data valid.
- avmm_waitrequest  out  1  Constant 0.
- ch_fpga_mac  out  NUM_CHANNELS*48  Active FPGA MAC per channel.
- ch_fpga_ip, ch_fpga_netmask, ch_host_ip  out  NUM_CHANNELS*32 each  Active addresses / netmask.
- ch_host_mac  out  NUM_CHANNELS*48  Active host MAC.
- ch_fpga_port, ch_host_port, ch_payload_per_packet, ch_checksum_ip  out  NUM_CHANNELS*16 each.
- ch_misc_ctrl  out  NUM_CHANNELS*64  Active misc control.
- ch_csr_rst, ch_tx_rst, ch_rx_rst  out  NUM_CHANNELS each  Reset pulses.
- ch_tx_status, ch_rx_status  in  NUM_CHANNELS*32 each  Status inputs.
- ch_tx_pkt_done, ch_rx_pkt_done  in  NUM_CHANNELS each  One-cycle packet-done strobes.

Behaviour:
- Reset (rst=1): all outputs 0, including readdata and readdatavalid. Shadows, actives, pending flags, pulse counters, packet counters and scratchpad all clear to 0. A pulse in flight is aborted.
- Reads:
  - readdatavalid is asserted exactly 1 cycle after avmm_read; no back-pressure.
  - Unmapped offsets, and channel index ≥ NUM_CHANNELS, return REG_RD_BADADDR_DATA.
  - Simultaneous read and write to the same register: the read returns the pre-write value.
- Writes:
  - Take effect at the clock edge where write=1.
  - Only byte lanes with byteenable=1 update. Bits above a register's field width are ignored.
  - Writes to read-only or unmapped registers are dropped.
- Global words:
  - 0 DFH header.
  - 1 ID_LO.
  - 2 ID_HI.
  - 3 NEXT_AFU_OFFSET.
  - 4 SCRATCHPAD (RW 64).
  - 5 NUM_CH (RO, = NUM_CHANNELS).
- Channel words:
  - 0 FPGA_MAC.
  - 1 FPGA_IP.
  - 2 FPGA_PORT.
  - 3 NETMASK.
  - 4 HOST_MAC.
  - 5 HOST_IP.
  - 6 HOST_PORT.
  - 7 PAYLOAD.
  - 8 CHECKSUM.
  - 9 RESET.
  - 10 STATUS, RO = {tx_status, rx_status}.
  - 11 MISC.
  - 12 COMMIT.
  - 13 TX_PKT_CNT.
  - 14 RX_PKT_CNT.
- Shadow/commit (words 0-8, 11):
  - Writes update the shadow copy and set that channel's pending flag. Reads return the shadow.
  - Writing COMMIT with bit0=1 copies all shadows to active outputs; active outputs change 1 cycle after the write edge, and pending clears.
  - A config write and a commit in the same cycle cannot occur (single port).
  - A COMMIT read returns {63'b0, pending}.
- RESET word:
  - Writing bits [2:0]={csr,tx,rx} loads a per-bit down-counter with RST_PULSE_CYCLES. The corresponding output is high while its counter is nonzero, i.e. exactly RST_PULSE_CYCLES cycles, starting the cycle after the write.
  - A rewrite during a pulse reloads the counter (extends the pulse). Writing 0 does not cut a pulse short.
  - A read returns the current output levels.
- Packet counters:
  - Increment by 1 per done strobe and saturate at all-ones.
  - A read returns the current value. On the same edge the counter loads 0, or 1 if a strobe coincides, so no events are lost.

Decomposition:
- uoe_csr_mc_pkg holds:
  - DFH fields, ID_LO/HI, NEXT_AFU_OFFSET, REG_RD_BADADDR_DATA;
  - global and channel word-offset localparams;
  - a ch_cfg_t struct (mac/ip/port/netmask/payload/checksum/misc).
- One sub-module, uoe_csr_ch_bank, instantiated NUM_CHANNELS times. It contains shadow/active regs, commit, pulse counters, packet counters and its own read mux. The top level does address decode and the final read mux.

Test Plan:
- Reset, then read word 5 -> 2. Read word 0x00F -> REG_RD_BADADDR_DATA. Read ch2 base (0x300) with NUM_CHANNELS=2 -> REG_RD_BADADDR_DATA. readdatavalid appears 1 cycle after read.
- Write ch0 FPGA_IP=0xC0A80001 with byteenable=0x03 after 0xFFFFFFFF -> readback 0xFFFF0001. ch_fpga_ip[31:0] stays 0 and COMMIT reads 1. Write COMMIT=1 -> output 0xFFFF0001 the next cycle; COMMIT reads 0.
- Write ch1 RESET=0b010 -> ch_tx_rst[1] high for exactly 16 cycles. Rewrite at cycle 10 -> 26 cycles total high. Other channels unaffected.
- Drive 5 tx_pkt_done strobes on ch0 -> TX_PKT_CNT reads 5. Read with a coincident strobe -> returns 5, next read returns 1.
- Force CNT_W=4 and drive 20 strobes -> reads 15 (saturated).
- Assert rst during an active pulse with pending=1 -> pulse drops the next cycle; pending=0; actives 0.
